// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_TIMEOUT_EN (adds the RESP watchdog and ERR state).
package dmem_arbiter_pkg;

    // Arbiter FSM states; ERR is only reachable when the watchdog is compiled in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } arb_state_e;

    // Largest supported core count.
    localparam int MAX_CORES = 8;

    // Width of an owner / round-robin pointer for n cores (never below 1 bit).
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Request bundle toward the data memory.
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_out_s;

    // Handshake and response bundle coming back from the data memory.
    typedef struct packed {
        logic        yumi;
        logic        rsp_valid;
        logic [31:0] rsp_data;
    } mem_in_s;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after
// i_ptr (wrapping modulo num_cores_p) wins.
module rr_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int  num_cores_p = 2,
    localparam int OW          = owner_width(num_cores_p)
) (
    input  logic [num_cores_p-1:0] i_req,
    input  logic [OW-1:0]          i_ptr,
    output logic [num_cores_p-1:0] o_grant,
    output logic [OW-1:0]          o_idx,
    output logic                   o_valid
);

    localparam logic [OW:0] L_N = (OW+1)'(num_cores_p);

    logic [OW:0]   w_sum [num_cores_p];
    logic [OW-1:0] w_idx [num_cores_p];
    logic          w_valid;
    logic [OW-1:0] w_sel;

    // Candidate index for each scan position: (i_ptr + gi) mod num_cores_p.
    // i_ptr < num_cores_p, so a single conditional subtract wraps it.
    genvar gi;
    generate
        for (gi = 0; gi < num_cores_p; gi++) begin : g_rot
            assign w_sum[gi] = {1'b0, i_ptr} + (OW+1)'(gi);
            assign w_idx[gi] = (w_sum[gi] >= L_N) ? OW'(w_sum[gi] - L_N) : w_sum[gi][OW-1:0];
        end
    endgenerate

    // Scan candidates in rotated order and keep the first requester.
    always_comb begin
        w_valid = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < num_cores_p; k++) begin
            if (!w_valid && i_req[w_idx[k]]) begin
                w_valid = 1'b1;
                w_sel   = w_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < num_cores_p; gi++) begin : g_grant
            assign o_grant[gi] = w_valid && (w_sel == OW'(gi));
        end
    endgenerate

    assign o_idx   = w_sel;
    assign o_valid = w_valid;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between num_cores_p cores, one transaction at a time.
// Optional feature macro: DMEM_ARB_TIMEOUT_EN (RESP watchdog, sticky ERR state, err_o port).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int  num_cores_p = 2,
    parameter int  timeout_p   = 64,
    localparam int OW          = owner_width(num_cores_p)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [num_cores_p-1:0]    req_valid_i,
    input  logic [num_cores_p-1:0]    req_wen_i,
    input  logic [num_cores_p-1:0]    req_byte_i,
    input  logic [32*num_cores_p-1:0] req_addr_i,
    input  logic [32*num_cores_p-1:0] req_wdata_i,
    output logic [num_cores_p-1:0]    req_yumi_o,
    output logic [num_cores_p-1:0]    rsp_valid_o,
    output logic [31:0]               rsp_data_o,
    input  logic [num_cores_p-1:0]    rsp_yumi_i,
    output logic                      mem_valid_o,
    output logic                      mem_wen_o,
    output logic                      mem_byte_o,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    input  logic                      mem_yumi_i,
    input  logic                      mem_rsp_valid_i,
    input  logic [31:0]               mem_rsp_data_i,
    output logic                      mem_rsp_yumi_o,
    output logic [OW-1:0]             owner_o,
    output logic                      busy_o
`ifdef DMEM_ARB_TIMEOUT_EN
    ,
    output logic                      err_o
`endif
);

    arb_state_e    r_state;
    logic [OW-1:0] r_rr_ptr;
    logic [OW-1:0] r_owner;
    logic          r_wen;
    logic          r_byte;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    logic [31:0]            w_core_addr  [num_cores_p];
    logic [31:0]            w_core_wdata [num_cores_p];
    logic [num_cores_p-1:0] w_grant;
    logic [OW-1:0]          w_win_idx;
    logic                   w_win_valid;
    logic                   w_sel_wen;
    logic                   w_sel_byte;
    logic [31:0]            w_sel_addr;
    logic [31:0]            w_sel_wdata;
    logic                   w_live;
    logic                   w_issue;
    logic                   w_resp;
    logic                   w_done;
    logic [OW-1:0]          w_next_ptr;
    mem_in_s                w_mem_in;
    mem_out_s               w_mem_out;

    genvar gi;
    generate
        for (gi = 0; gi < num_cores_p; gi++) begin : g_unpack
            assign w_core_addr[gi]  = req_addr_i[gi*32 +: 32];
            assign w_core_wdata[gi] = req_wdata_i[gi*32 +: 32];
        end
    endgenerate

    rr_arbiter #(
        .num_cores_p (num_cores_p)
    ) u_rr (
        .i_req   (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    // Select the winning core's request fields using the one-hot grant.
    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_byte  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < num_cores_p; k++) begin
            if (w_grant[k]) begin
                w_sel_wen   = req_wen_i[k];
                w_sel_byte  = req_byte_i[k];
                w_sel_addr  = w_core_addr[k];
                w_sel_wdata = w_core_wdata[k];
            end
        end
    end

    assign w_mem_in   = '{yumi: mem_yumi_i, rsp_valid: mem_rsp_valid_i, rsp_data: mem_rsp_data_i};
    assign w_done     = w_mem_in.rsp_valid & rsp_yumi_i[r_owner];
    assign w_next_ptr = (r_owner == OW'(num_cores_p - 1)) ? '0 : r_owner + OW'(1);

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(timeout_p + 1);
    logic [TW-1:0] r_timer;
`else
    // timeout_p only matters when the watchdog is compiled in.
    logic w_unused_timeout;
    assign w_unused_timeout = (timeout_p > 0);
`endif

    // Arbiter FSM: latch the winner in IDLE, hold it in ISSUE, wait for the owner to take the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_wen    <= 1'b0;
            r_byte   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_timer  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_owner <= w_win_idx;
                        r_wen   <= w_sel_wen;
                        r_byte  <= w_sel_byte;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_mem_in.yumi) begin
                        r_state <= RESP;
`ifdef DMEM_ARB_TIMEOUT_EN
                        r_timer <= '0;
`endif
                    end
                end
                RESP: begin
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else if (r_timer == TW'(timeout_p - 1)) begin
                        r_state <= ERR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
`endif
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                ERR: r_state <= ERR;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state and forced to zero while reset is held.
    assign w_live  = ~reset;
    assign w_issue = w_live && (r_state == ISSUE);
    assign w_resp  = w_live && (r_state == RESP);

    assign w_mem_out = '{
        valid:         w_issue,
        wen:           w_issue & r_wen,
        byte_not_word: w_issue & r_byte,
        addr:          w_issue ? r_addr : 32'd0,
        wdata:         w_issue ? r_wdata : 32'd0
    };

    assign mem_valid_o = w_mem_out.valid;
    assign mem_wen_o   = w_mem_out.wen;
    assign mem_byte_o  = w_mem_out.byte_not_word;
    assign mem_addr_o  = w_mem_out.addr;
    assign mem_wdata_o = w_mem_out.wdata;

    generate
        for (gi = 0; gi < num_cores_p; gi++) begin : g_route
            assign req_yumi_o[gi]  = w_issue && w_mem_in.yumi && (r_owner == OW'(gi));
            assign rsp_valid_o[gi] = w_resp && w_mem_in.rsp_valid && (r_owner == OW'(gi));
        end
    endgenerate

    assign rsp_data_o     = w_resp ? w_mem_in.rsp_data : 32'd0;
    assign mem_rsp_yumi_o = w_resp & w_done;
    assign owner_o        = (w_live && (r_state != ERR)) ? r_owner : '0;
    assign busy_o         = w_live && (r_state != IDLE);
`ifdef DMEM_ARB_TIMEOUT_EN
    assign err_o          = w_live && (r_state == ERR);
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one data-memory port between num_cores_p cores, using the existing valid/yumi request and response handshake.
- Picks one requester round-robin and latches its request. Drives the request to memory until memory accepts it.
- Forwards the response to the owning core only, then releases the port.
- One transaction is outstanding at a time. Sits between the core instances' to_mem/from_mem ports and the single data memory.

Parameters:
- num_cores_p, 2, number of requesting cores (2..8).
- timeout_p, 64, RESP-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  num_cores_p  per-core request valid (core to_mem valid).
- req_wen_i  in  num_cores_p  per-core store flag.
- req_byte_i  in  num_cores_p  per-core byte_not_word.
- req_addr_i  in  32*num_cores_p  per-core address; slice i*32 belongs to core i.
- req_wdata_i  in  32*num_cores_p  per-core write data.
- req_yumi_o  out  num_cores_p  request accepted by memory (core from_mem yumi).
- rsp_valid_o  out  num_cores_p  response valid (core from_mem valid).
- rsp_data_o  out  32  read data, broadcast to all cores; qualified by rsp_valid_o.
- rsp_yumi_i  in  num_cores_p  core consumes the response (core to_mem yumi).
- mem_valid_o  out  1  request valid to memory.
- mem_wen_o  out  1  store flag to memory.
- mem_byte_o  out  1  byte_not_word to memory.
- mem_addr_o  out  32  address to memory.
- mem_wdata_o  out  32  write data to memory.
- mem_yumi_i  in  1  memory accepted the request.
- mem_rsp_valid_i  in  1  memory response valid.
- mem_rsp_data_i  in  32  memory read data.
- mem_rsp_yumi_o  out  1  response consumed, to memory.
- owner_o  out  $clog2(num_cores_p)  current or last owner (debug).
- busy_o  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, RESP, plus ERR when the optional feature is compiled in. All state transitions and register updates occur on posedge clk.
- Reset (any cycle, including mid-transaction): state=IDLE, rr_ptr=0, owner=0, latched request=0, timer=0. Every output is 0.
- IDLE:
  - The winner is the first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo num_cores_p.
  - If a winner exists, latch its wen/byte/addr/wdata, set owner=i, go to ISSUE next cycle.
  - Otherwise stay in IDLE. mem_valid_o=0.
- ISSUE:
  - mem_valid_o=1; mem_* come from the latched registers, so requester changes are ignored.
  - req_yumi_o[owner] = mem_yumi_i (combinational); all other bits are 0.
  - On mem_yumi_i=1, go to RESP.
- RESP:
  - rsp_valid_o[owner] = mem_rsp_valid_i; rsp_data_o = mem_rsp_data_i; mem_rsp_yumi_o = rsp_yumi_i[owner] & mem_rsp_valid_i.
  - On mem_rsp_valid_i & rsp_yumi_i[owner]: go to IDLE and set rr_ptr = owner+1 (wraps num_cores_p-1 to 0).
- Latency: a request first seen in IDLE at cycle t drives memory from t+1. Minimum full transaction is 3 cycles; the port can re-arbitrate in the cycle after completion.
- Boundaries:
  - Same-cycle mem_yumi_i and mem_rsp_valid_i in ISSUE: the response is ignored until RESP; memory must hold it valid.
  - rsp_yumi_i from a non-owner is ignored.
  - Dropping req_valid_i after latch is a protocol violation; the latched transaction still completes.
  - A single requester back-to-back gets the port every 3 cycles.
  - Round-robin fairness: each of N continuously requesting cores is granted within N transactions.

Optional Feature:
- Macro DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A timer counts RESP cycles and is cleared on RESP entry.
  - Reaching timeout_p with no completion goes to ERR.
  - ERR is sticky until reset: all outputs 0 except busy_o=1; err_o=1.
  - err_o is an added 1-bit output port.
- Undefined: no timer, no ERR state, no err_o port; RESP waits indefinitely.

Decomposition:
- Shared package entries: arb_state_e (IDLE, ISSUE, RESP, ERR) and localparam owner width $clog2(num_cores_p).
- Reuse the existing mem_in_s/mem_out_s for top-level wiring only.
- One sub-module: rr_arbiter. Combinational priority rotate on req vector plus rr_ptr, giving a grant one-hot and a valid.

Test Plan:
- Reset during RESP -> next cycle state=IDLE, mem_valid_o=0, rsp_valid_o=0, rr_ptr=0.
- Core0 load addr 0x10; mem_yumi_i at t+2, mem_rsp_valid_i data 0xDEADBEEF at t+4; core0 yumi -> req_yumi_o=01 at t+2, rsp_valid_o=01 with data 0xDEADBEEF at t+4, IDLE at t+5.
- Cores 0 and 1 request continuously, N=2 -> grants alternate 0,1,0,1 across 4 transactions.
- Core1 changes req_addr_i from 0x20 to 0x30 during ISSUE -> mem_addr_o stays 0x20.
- mem_rsp_valid_i held 3 cycles, owner rsp_yumi_i asserted only on the 3rd -> mem_rsp_yumi_o high only on the 3rd cycle; non-owner yumi ignored.
- With DMEM_ARB_TIMEOUT_EN and timeout_p=8: no response -> err_o=1 8 cycles after RESP entry; stays 1 until reset.
